// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer with prescaler, reload-on-overflow, level IRQ and a free-running
// SYSTICK counter. Software writes beat hardware updates that land on the same edge.
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        kernel_mode,
    output logic        IRQ
);

    localparam logic [31:0] ThAddr      = BASE_ADDR;
    localparam logic [31:0] TlAddr      = BASE_ADDR + 32'h4;
    localparam logic [31:0] TconAddr    = BASE_ADDR + 32'h8;
    localparam logic [31:0] SystickAddr = BASE_ADDR + 32'h14;
    localparam logic [15:0] PsMax       = 16'(PRESCALE - 1);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [31:0] r_systick;
    logic [15:0] r_ps;

    logic w_sel_th;
    logic w_sel_tl;
    logic w_sel_tcon;
    logic w_sel_systick;
    logic w_wr_th;
    logic w_wr_tl;
    logic w_wr_tcon;
    logic w_tick;
    logic w_overflow;

    // Byte-lane bits are ignored: decode on the word address only.
    assign w_sel_th      = (Addr[31:2] == ThAddr[31:2]);
    assign w_sel_tl      = (Addr[31:2] == TlAddr[31:2]);
    assign w_sel_tcon    = (Addr[31:2] == TconAddr[31:2]);
    assign w_sel_systick = (Addr[31:2] == SystickAddr[31:2]);

    assign w_wr_th   = MemWr & w_sel_th;
    assign w_wr_tl   = MemWr & w_sel_tl;
    assign w_wr_tcon = MemWr & w_sel_tcon;

    assign w_tick     = r_tcon[0] & (r_ps == PsMax);
    assign w_overflow = w_tick & (r_tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'h1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= 32'h0;
        end else if (w_wr_th) begin
            r_th <= WriteData;
        end
    end

    // A TL write restarts the prescale period so the new value gets a full interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ps <= 16'h0;
        end else if (w_wr_tl) begin
            r_ps <= 16'h0;
        end else if (r_tcon[0]) begin
            r_ps <= w_tick ? 16'h0 : r_ps + 16'h1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= 32'h0;
        end else if (w_wr_tl) begin
            r_tl <= WriteData;
        end else if (w_overflow) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + 32'h1;
        end
    end

    // Status only latches on overflow when irq_en is set and software is not writing TCON.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= 3'b000;
        end else if (w_wr_tcon) begin
            r_tcon <= WriteData[2:0];
        end else if (w_overflow && r_tcon[1]) begin
            r_tcon[2] <= 1'b1;
        end
    end

    assign IRQ = r_tcon[2] & r_tcon[1] & ~kernel_mode;

    always_comb begin
        ReadData = 32'h0;
        if (MemRd && !reset) begin
            if (w_sel_th) begin
                ReadData = r_th;
            end else if (w_sel_tl) begin
                ReadData = r_tl;
            end else if (w_sel_tcon) begin
                ReadData = {29'h0, r_tcon};
            end else if (w_sel_systick) begin
                ReadData = r_systick;
            end
        end
    end

endmodule
